// File: rtl/fifo_pkg.sv
// Shared constants and FSM encoding for the synchronous FIFO and its write-side arbiter.
package fifo_pkg;

    localparam int FIFO_DATA_W   = 32;
    localparam int FIFO_DEPTH    = 16;
    localparam int ARB_MAX_BURST = 8;
    localparam int ARB_BURST_LOG = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or after rr_ptr, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int REQ_LOG = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [REQ_LOG-1:0] rr_ptr,
    output logic               found,
    output logic [REQ_LOG-1:0] idx
);

    logic [REQ_LOG-1:0] cand;

    // NUM_REQ is a power of two, so the REQ_LOG-bit add wraps for free.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = rr_ptr + REQ_LOG'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-locked round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int REQ_LOG    = 2,
    parameter int DATA_WIDTH = FIFO_DATA_W,
    parameter int MAX_BURST  = ARB_MAX_BURST,
    parameter int BURST_LOG  = ARB_BURST_LOG
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] data,
    output logic [NUM_REQ-1:0]            ack,
    input  logic                          fifo_full,
    output logic                          fifo_cs,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic                          gnt_valid,
    output logic [REQ_LOG-1:0]            gnt_id,
    output logic                          busy
);

    arb_state_t           state;
    logic [REQ_LOG-1:0]   rr_ptr;
    logic [BURST_LOG-1:0] beat_cnt;
    logic                 pick_found;
    logic [REQ_LOG-1:0]   pick_idx;
    logic                 in_burst;
    logic                 accept;
    logic                 at_max;
    logic                 burst_end;
    logic [DATA_WIDTH-1:0] words [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
        assign words[g] = data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .REQ_LOG (REQ_LOG)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .idx    (pick_idx)
    );

    // Accept is combinational so a granted producer is acked in the same cycle it presents data.
    assign in_burst  = (state == BURST);
    assign accept    = in_burst && req[gnt_id] && !fifo_full;
    assign at_max    = (beat_cnt == BURST_LOG'(MAX_BURST - 1));
    assign burst_end = in_burst && (!req[gnt_id] || (accept && (last[gnt_id] || at_max)));

    assign gnt_valid    = in_burst;
    assign fifo_wr_en   = accept;
    assign fifo_cs      = accept;
    assign ack          = accept ? (NUM_REQ'(1) << gnt_id) : '0;
    assign fifo_data_in = in_burst ? words[gnt_id] : '0;
    // Gated by rst so every output reads zero while reset is held, even with requests pending.
    assign busy         = !rst && (in_burst || (en && (|req)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            gnt_id   <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && pick_found) begin
                        gnt_id   <= pick_idx;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (burst_end) begin
                        state  <= IDLE;
                        rr_ptr <= gnt_id + 1'b1;
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: grant order, burst limits, stalls, release, enable and reset.
module tb_fifo_wr_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic [3:0]   req = '0;
    logic [3:0]   last = '0;
    logic [127:0] data = '0;
    logic         fifo_full = 1'b0;
    logic [3:0]   ack;
    logic         fifo_cs;
    logic         fifo_wr_en;
    logic [31:0]  fifo_data_in;
    logic         gnt_valid;
    logic [1:0]   gnt_id;
    logic         busy;

    int checks = 0;
    int passes = 0;
    int seq [4];
    logic [31:0] fifo_log [$];

    logic        s_gv, s_wr, s_cs, s_busy;
    logic [1:0]  s_gid;
    logic [3:0]  s_ack;
    logic [31:0] s_data;

    fifo_wr_arbiter #(
        .NUM_REQ    (4),
        .REQ_LOG    (2),
        .DATA_WIDTH (32),
        .MAX_BURST  (8),
        .BURST_LOG  (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .req          (req),
        .last         (last),
        .data         (data),
        .ack          (ack),
        .fifo_full    (fifo_full),
        .fifo_cs      (fifo_cs),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_data_in (fifo_data_in),
        .gnt_valid    (gnt_valid),
        .gnt_id       (gnt_id),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input int p, input int s);
        return {8'(32'hA0 + p), 24'(s)};
    endfunction

    function automatic logic [40:0] beat_vec(input int g, input int k);
        return {1'b1, 2'(g), 1'b1, 1'b1, 4'(1 << g), word(g, k)};
    endfunction

    task automatic drive_data();
        for (int i = 0; i < 4; i++) data[i*32 +: 32] = word(i, seq[i]);
    endtask

    // Called at a falling edge with inputs set; samples, crosses one rising edge, advances producers.
    task automatic step();
        drive_data();
        #1;
        s_gv = gnt_valid; s_gid = gnt_id; s_wr = fifo_wr_en; s_cs = fifo_cs;
        s_ack = ack; s_data = fifo_data_in; s_busy = busy;
        if (fifo_wr_en) fifo_log.push_back(fifo_data_in);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (s_ack[i]) seq[i]++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; last = '0; en = 1'b0; fifo_full = 1'b0;
        for (int i = 0; i < 4; i++) seq[i] = 0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; req = 4'b1111;
        for (int i = 0; i < 4; i++) seq[i] = 0;
        drive_data();
        @(negedge clk);
        #1;
        checks++;
        if ({gnt_valid, gnt_id, fifo_wr_en, fifo_cs, ack, busy, fifo_data_in} !== 42'd0)
            $display("FAIL reset_outputs: got %h want 0",
                     {gnt_valid, gnt_id, fifo_wr_en, fifo_cs, ack, busy, fifo_data_in});
        else passes++;
        @(negedge clk);
        rst = 1'b0; req = '0; en = 1'b0;
        step();
        checks++;
        if ({s_gv, s_wr, s_cs, s_ack, s_busy} !== 8'd0)
            $display("FAIL reset_idle: got %b want 0", {s_gv, s_wr, s_cs, s_ack, s_busy});
        else passes++;
    endtask

    task automatic test_basic();
        en = 1'b1; req = 4'b0001; last = '0;
        step();
        checks++;
        if ({s_gv, s_wr, s_cs, s_ack, s_busy} !== 8'b0000_0001)
            $display("FAIL basic_arb_cycle: got %b want 00000001", {s_gv, s_wr, s_cs, s_ack, s_busy});
        else passes++;
        for (int k = 0; k < 3; k++) begin
            last = (k == 2) ? 4'b0001 : 4'b0000;
            step();
            checks++;
            if ({s_gv, s_gid, s_wr, s_cs, s_ack, s_data} !== beat_vec(0, k))
                $display("FAIL basic_beat%0d: got %h want %h", k,
                         {s_gv, s_gid, s_wr, s_cs, s_ack, s_data}, beat_vec(0, k));
            else passes++;
        end
        req = 4'b0011; last = '0;
        step();
        checks++;
        if ({s_gv, s_wr, s_cs, s_ack} !== 7'd0)
            $display("FAIL basic_idle_after_last: got %b want 0", {s_gv, s_wr, s_cs, s_ack});
        else passes++;
        step();
        checks++;
        if ({s_gv, s_gid, s_wr, s_cs, s_ack, s_data} !== beat_vec(1, 0))
            $display("FAIL basic_rr_ptr_next: got %h want %h",
                     {s_gv, s_gid, s_wr, s_cs, s_ack, s_data}, beat_vec(1, 0));
        else passes++;
        do_reset();
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        int exp_seq [4] = '{0, 0, 0, 0};
        en = 1'b1; req = 4'b1111; last = '0;
        for (int n = 0; n < 5; n++) begin
            step();
            checks++;
            if ({s_gv, s_wr, s_cs, s_ack} !== 7'd0)
                $display("FAIL rr_gap%0d: got %b want 0", n, {s_gv, s_wr, s_cs, s_ack});
            else passes++;
            for (int k = 0; k < 8; k++) begin
                step();
                checks++;
                if ({s_gv, s_gid, s_wr, s_cs, s_ack, s_data} !== beat_vec(order[n], exp_seq[order[n]]))
                    $display("FAIL rr_grant%0d_beat%0d: got %h want %h", n, k,
                             {s_gv, s_gid, s_wr, s_cs, s_ack, s_data},
                             beat_vec(order[n], exp_seq[order[n]]));
                else passes++;
                exp_seq[order[n]]++;
            end
        end
        step();
        checks++;
        if ({s_gv, s_wr, s_cs, s_ack} !== 7'd0)
            $display("FAIL rr_final_gap: got %b want 0", {s_gv, s_wr, s_cs, s_ack});
        else passes++;
        do_reset();
    endtask

    task automatic test_full_stall();
        fifo_log.delete();
        en = 1'b1; req = 4'b0100; last = '0;
        step();
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if ({s_gv, s_gid, s_wr, s_cs, s_ack, s_data} !== beat_vec(2, k))
                $display("FAIL stall_pre%0d: got %h want %h", k,
                         {s_gv, s_gid, s_wr, s_cs, s_ack, s_data}, beat_vec(2, k));
            else passes++;
        end
        fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if ({s_gv, s_gid, s_wr, s_cs, s_ack} !== 9'b1_10_0_0_0000)
                $display("FAIL stall_full%0d: got %b want 110000000", k,
                         {s_gv, s_gid, s_wr, s_cs, s_ack});
            else passes++;
        end
        fifo_full = 1'b0;
        for (int k = 2; k < 8; k++) begin
            step();
            checks++;
            if ({s_gv, s_gid, s_wr, s_cs, s_ack, s_data} !== beat_vec(2, k))
                $display("FAIL stall_post%0d: got %h want %h", k,
                         {s_gv, s_gid, s_wr, s_cs, s_ack, s_data}, beat_vec(2, k));
            else passes++;
        end
        req = '0;
        step();
        checks++;
        if ({s_gv, s_wr} !== 2'b00)
            $display("FAIL stall_burst_end: got %b want 00", {s_gv, s_wr});
        else passes++;
        checks++;
        if (fifo_log.size() != 8)
            $display("FAIL stall_word_count: got %0d want 8", fifo_log.size());
        else passes++;
        for (int i = 0; i < fifo_log.size() && i < 8; i++) begin
            checks++;
            if (fifo_log[i] !== word(2, i))
                $display("FAIL stall_fifo_word%0d: got %h want %h", i, fifo_log[i], word(2, i));
            else passes++;
        end
        do_reset();
    endtask

    task automatic test_req_drop();
        en = 1'b1; req = 4'b0010; last = '0;
        step();
        req = 4'b1010;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if ({s_gv, s_gid, s_wr, s_cs, s_ack, s_data} !== beat_vec(1, k))
                $display("FAIL drop_beat%0d: got %h want %h", k,
                         {s_gv, s_gid, s_wr, s_cs, s_ack, s_data}, beat_vec(1, k));
            else passes++;
        end
        req = 4'b1000;
        step();
        checks++;
        if ({s_gv, s_gid, s_wr, s_cs, s_ack} !== 9'b1_01_0_0_0000)
            $display("FAIL drop_release: got %b want 101000000", {s_gv, s_gid, s_wr, s_cs, s_ack});
        else passes++;
        req = 4'b1010;
        step();
        checks++;
        if ({s_gv, s_wr, s_cs, s_ack} !== 7'd0)
            $display("FAIL drop_idle: got %b want 0", {s_gv, s_wr, s_cs, s_ack});
        else passes++;
        last = 4'b1000;
        step();
        checks++;
        if ({s_gv, s_gid, s_wr, s_cs, s_ack, s_data} !== beat_vec(3, 0))
            $display("FAIL drop_next_is_3: got %h want %h",
                     {s_gv, s_gid, s_wr, s_cs, s_ack, s_data}, beat_vec(3, 0));
        else passes++;
        req = 4'b0010; last = '0;
        step();
        step();
        checks++;
        if ({s_gv, s_gid, s_wr, s_cs, s_ack, s_data} !== beat_vec(1, 2))
            $display("FAIL drop_rerequest_1: got %h want %h",
                     {s_gv, s_gid, s_wr, s_cs, s_ack, s_data}, beat_vec(1, 2));
        else passes++;
        do_reset();
    endtask

    task automatic test_enable();
        en = 1'b0; req = 4'b0110; last = '0;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if ({s_gv, s_wr, s_ack, s_busy} !== 7'd0)
                $display("FAIL en_off%0d: got %b want 0", k, {s_gv, s_wr, s_ack, s_busy});
            else passes++;
        end
        en = 1'b1;
        step();
        checks++;
        if ({s_gv, s_wr, s_busy} !== 3'b001)
            $display("FAIL en_on_arb: got %b want 001", {s_gv, s_wr, s_busy});
        else passes++;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) en = 1'b0;
            last = (k == 2) ? 4'b0010 : 4'b0000;
            step();
            checks++;
            if ({s_gv, s_gid, s_wr, s_cs, s_ack, s_data} !== beat_vec(1, k))
                $display("FAIL en_burst_beat%0d: got %h want %h", k,
                         {s_gv, s_gid, s_wr, s_cs, s_ack, s_data}, beat_vec(1, k));
            else passes++;
        end
        last = '0;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if ({s_gv, s_wr, s_busy} !== 3'b000)
                $display("FAIL en_no_regrant%0d: got %b want 000", k, {s_gv, s_wr, s_busy});
            else passes++;
        end
        do_reset();
    endtask

    task automatic test_reset_mid_burst();
        en = 1'b1; req = 4'b0100; last = 4'b0100;
        step();
        step();
        last = '0;
        step();
        for (int k = 1; k < 4; k++) begin
            step();
            checks++;
            if ({s_gv, s_gid, s_wr, s_cs, s_ack, s_data} !== beat_vec(2, k))
                $display("FAIL rstmid_beat%0d: got %h want %h", k,
                         {s_gv, s_gid, s_wr, s_cs, s_ack, s_data}, beat_vec(2, k));
            else passes++;
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({gnt_valid, gnt_id, fifo_wr_en, fifo_cs, ack, busy, fifo_data_in} !== 42'd0)
            $display("FAIL rstmid_async_outputs: got %h want 0",
                     {gnt_valid, gnt_id, fifo_wr_en, fifo_cs, ack, busy, fifo_data_in});
        else passes++;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) seq[i] = 0;
        req = 4'b1010; last = 4'b0010;
        step();
        step();
        checks++;
        if ({s_gv, s_gid, s_wr, s_cs, s_ack, s_data} !== beat_vec(1, 0))
            $display("FAIL rstmid_ptr_cleared: got %h want %h",
                     {s_gv, s_gid, s_wr, s_cs, s_ack, s_data}, beat_vec(1, 0));
        else passes++;
        req = 4'b1000; last = 4'b1000;
        step();
        step();
        checks++;
        if ({s_gv, s_gid, s_wr, s_cs, s_ack, s_data} !== beat_vec(3, 0))
            $display("FAIL rstmid_grant3: got %h want %h",
                     {s_gv, s_gid, s_wr, s_cs, s_ack, s_data}, beat_vec(3, 0));
        else passes++;
        do_reset();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_full_stall();
        test_req_drop();
        test_enable();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares the single write port of the team's synchronous FIFO among NUM_REQ producers. Grants are burst-locked: a granted producer keeps the port until it signals last, hits MAX_BURST beats, or drops its request. The block drives the FIFO chip-select, write-enable and write data, and throttles on the FIFO full flag, so no write is ever issued into a full FIFO.

Parameters:
NUM_REQ, 4, number of producers (power of two, >=2)
REQ_LOG, 2, log2(NUM_REQ); width of grant index
DATA_WIDTH, 32, word width; must equal the FIFO DATA_WIDTH
MAX_BURST, 8, maximum beats per grant (power of two, >=2)
BURST_LOG, 3, log2(MAX_BURST); beat counter width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  arbitration enable; 0 blocks new grants, an active burst still completes
req  in  NUM_REQ  per-producer request / data-valid
last  in  NUM_REQ  per-producer end-of-burst marker, qualified by req
data  in  NUM_REQ*DATA_WIDTH  producer words; producer i at bits [i*DATA_WIDTH +: DATA_WIDTH]
ack  out  NUM_REQ  one-hot; ack[i]=1 means producer i's word was written this cycle
fifo_full  in  1  FIFO full flag
fifo_cs  out  1  FIFO chip select
fifo_wr_en  out  1  FIFO write enable
fifo_data_in  out  DATA_WIDTH  FIFO write data
gnt_valid  out  1  a grant is active (BURST state)
gnt_id  out  REQ_LOG  index of the granted producer; held during a grant
busy  out  1  equals gnt_valid or (en and |req)

Behaviour:
- Reset (rst=1, async): state=IDLE, rr_ptr=0, gnt_id=0, beat_cnt=0. All outputs 0.
- FSM states: IDLE, BURST.
- IDLE: if en and |req, pick the first set req at or after rr_ptr (wrapping modulo NUM_REQ). Register gnt_id and clear beat_cnt; go to BURST next cycle. Arbitration latency is 1 cycle, and no write happens in IDLE.
- BURST: accept = req[gnt_id] and !fifo_full. Accept is combinational, giving zero-cycle accept.
- On accept: fifo_wr_en=1, fifo_cs=1, fifo_data_in=data[gnt_id], ack[gnt_id]=1, beat_cnt+1.
- Otherwise fifo_wr_en=0, ack=0. fifo_cs equals fifo_wr_en. fifo_data_in is don't-care when not writing; drive data[gnt_id].
- Burst end, checked in BURST state; the next state is IDLE, rr_ptr = gnt_id+1 (wrapping), gnt_valid drops next cycle. The burst ends when any of these holds:
  (a) accept and last[gnt_id];
  (b) accept and beat_cnt == MAX_BURST-1;
  (c) req[gnt_id]==0, which releases the grant with no write.
- fifo_full in BURST with req held: stall, hold grant, beat_cnt unchanged. There is no timeout.
- Minimum per-grant overhead is 1 idle cycle, so each grant occupies at most MAX_BURST+1 cycles plus stalls.
- en deassert mid-burst has no effect on the current burst. The IDLE check uses en.
- Requests from non-granted producers are ignored (ack=0); producers hold data until acked.
- Fairness: after producer k's grant, every other requesting producer is served before k again.
- NUM_REQ=4 wrap: rr_ptr 3 -> 0. The beat counter never exceeds MAX_BURST-1.
- Reset mid-burst: immediate return to IDLE, and the outputs drop asynchronously. A partial burst already written to the FIFO stays there.

Decomposition:
- Shared package fifo_pkg: FIFO and arbiter data width constant, default depth and burst constants, FSM state encoding (IDLE=1'b0, BURST=1'b1).
- One sub-module, rr_pick: combinational round-robin priority pick. Inputs req, rr_ptr; outputs found, idx. It is reused by any later read-side scheduler.

Test Plan:
1. Reset, then req=4'b0001, last asserted on the 3rd beat, fifo_full=0 -> gnt_valid at cycle 1; 3 consecutive writes with ack[0]; IDLE; rr_ptr=1.
2. req=4'b1111 held, last=0, MAX_BURST=8 -> grants in order 0,1,2,3,0. Each grant writes exactly 8 words, with a 1-cycle gap between grants.
3. Producer 2 in BURST, fifo_full=1 for 5 cycles mid-burst -> fifo_wr_en=0 and ack=0 for those 5 cycles, grant held, beat_cnt frozen. The remaining beats resume when full clears, and no word is lost or duplicated (scoreboard vs FIFO output).
4. Producer 1 drops req after 2 beats, no last -> grant released, next IDLE, rr_ptr=2. A pending req[3] is granted next, and req[1]'s re-request waits its turn.
5. en=0 with req=4'b0110 -> no grant, busy=0. Set en=1 -> producer 1 is granted. Deassert en mid-burst -> burst completes, then no new grant.
6. Assert rst mid-burst after 3 beats -> all outputs 0 immediately. After release, rr_ptr=0 and req=4'b1000 is granted producer 3 first.
